// File: rtl/spec_2demux_reg.sv
// spec_2demux_reg: registered 1-to-2 demultiplexer with valid/ready handshakes.
// A single input stream is steered by sel into one of two one-entry holding
// registers. Each branch drains on its own handshake and keeps a saturating
// count of accepted items.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   flush                 empties both holding registers (data/counters kept)
//   in_valid/in_ready     input handshake; in_ready depends on sel's branch only
//   in_data, sel          payload and destination (0 -> out0, 1 -> out1)
//   outK_valid/outK_ready branch K handshake
//   outK_data             branch K registered payload
//   cntK                  branch K accepted-item count, saturating
module spec_2demux_reg #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             sel,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [W-1:0]     out0_data,
  output logic [W-1:0]     out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [1:0]            br_ready;
  logic [1:0]            br_valid;
  logic [1:0]            br_load;
  logic [1:0][W-1:0]     br_data;
  logic [1:0][CNT_W-1:0] br_cnt;
  logic                  acc;

  assign br_ready = {out1_ready, out0_ready};

  // Only the addressed branch can stall the input; the other branch's
  // state never causes head-of-line blocking.
  assign in_ready = ~flush & (~br_valid[sel] | br_ready[sel]);
  assign acc      = in_valid & in_ready;

  for (genvar k = 0; k < 2; k++) begin : g_br
    assign br_load[k] = acc & (sel == 1'(k));

    spec_2demux_reg_branch #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_br (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (br_load[k]),
      .in_data (in_data),
      .ready   (br_ready[k]),
      .valid   (br_valid[k]),
      .data    (br_data[k]),
      .cnt     (br_cnt[k])
    );
  end

  assign out0_valid = br_valid[0];
  assign out1_valid = br_valid[1];
  assign out0_data  = br_data[0];
  assign out1_data  = br_data[1];
  assign cnt0       = br_cnt[0];
  assign cnt1       = br_cnt[1];

endmodule

// One output branch: EMPTY/FULL holding register plus saturating counter.
//   load     accept into this branch this cycle (never asserted with flush)
//   ready    downstream consumer accepts
//   valid    register full
//   data     held payload, keeps its last value when emptied
//   cnt      accepted items, saturating at all-ones
module spec_2demux_reg_branch #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [W-1:0]     in_data,
  input  logic             ready,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        data <= in_data;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  // A load wins over a same-cycle drain, so the branch sustains one item per
  // cycle without valid dropping.
  always_comb begin
    state_nxt = state;
    if (flush)                      state_nxt = EMPTY;
    else if (load)                  state_nxt = FULL;
    else if (state == FULL && ready) state_nxt = EMPTY;
  end

  assign valid = (state == FULL);

endmodule

// File: doc/spec_2demux_reg.md
# spec_2demux_reg

Registered 1-to-2 demultiplexer with valid/ready handshakes: the receive-side counterpart of the 2-input select mux. A single input stream is routed by `sel` to one of two output branches, each with a one-entry holding register, and per-branch transfer counts are kept. It sits downstream of the mux-based datapath and returns each item to the branch that `sel` names, so bench and proof harnesses can check end-to-end that the selected value arrives intact.

## Interface
Parameters:
- `W`, 1, data width of input and both outputs.
- `CNT_W`, 8, width of the per-branch saturating transfer counters.

Ports (one clock `clk`; `rst` is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous active-high reset.
- `flush`  input  1  synchronous clear of both holding registers (counters kept).
- `in_valid`  input  1  input item present.
- `in_ready`  output  1  block can accept the item addressed by `sel`.
- `in_data`  input  W  input payload.
- `sel`  input  1  destination branch: 0 → out0, 1 → out1; sampled only on accept.
- `out0_valid` / `out1_valid`  output  1  branch holding register full.
- `out0_ready` / `out1_ready`  input  1  branch consumer accepts.
- `out0_data` / `out1_data`  output  W  branch payload, registered.
- `cnt0` / `cnt1`  output  CNT_W  accepted items per branch, saturating.

## Operation
- Accept: `acc = in_valid & in_ready`. Transfer on branch k: `xk = outk_valid & outk_ready`.
- `in_ready = ~flush & (~out[sel]_valid | out[sel]_ready)`. It is combinational in `sel`, `flush`, and the addressed branch only. The other branch's state never stalls the input.
- On `acc` with `sel = k`: `outk_data <= in_data`, `outk_valid <= 1`, and `cntk` increments.
- On `xk` with no new accept into k: `outk_valid <= 0`. `outk_data` holds its last value.
- Same-cycle `xk` and accept into k: the register reloads with the new data and `outk_valid` stays 1. Branch throughput is 1 item/cycle.
- The non-selected branch is unaffected by `acc`. It drains independently.
- While `outk_valid & ~outk_ready`, `outk_data` and `outk_valid` are stable (AXI-style hold).
- `flush`: `out0_valid <= 0` and `out1_valid <= 0`. `in_ready` is 0, so no accept happens. Data registers and counters are unchanged.
- Counters: `cntk <= cntk + 1` on accept into k, unless `cntk == 2^CNT_W-1`, in which case it holds. There is no wrap.
- `in_data` and `sel` are don't-care when `in_valid = 0` and cause no state change.
- `rst` overrides `flush` and all handshakes.

## Timing
- Reset (`rst` sampled high): `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`, `cnt0 = cnt1 = 0`. `in_ready` reads 1 after reset when `flush = 0`.
- Latency: an item accepted at edge n appears on `outk_data` with `outk_valid = 1` after edge n (1 cycle).
- Combinational paths: `sel`, `flush`, `outk_ready` → `in_ready`. No path runs from `in_valid` or `in_data` to any output.
- Two per-branch states: EMPTY (`valid = 0`) and FULL (`valid = 1`).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with transfer, or on stall.
  - FULL→EMPTY on transfer without accept, or on flush.
- Reset asserted mid-stream discards held items. The next accept is the first counted item.

## Test plan
- Reset, then `in_valid = 1`, `sel = 0`, `in_data = 1`, `out0_ready = 1` for 4 cycles → `out0_valid = 1` from cycle 1, four transfers, `cnt0 = 4`, `cnt1 = 0`, `out1_valid = 0` throughout.
- Alternate `sel` 0,1,0,1 with data 1,0,0,1 (W=1), both readies high → `out0` sees 1,0 and `out1` sees 0,1, each valid 1 cycle after accept; `cnt0 = cnt1 = 2`.
- Back-pressure: fill out1 with `out1_ready = 0`, then present `sel = 1` → `in_ready = 0`, `out1_data` stable, counters frozen. Then present `sel = 0` in the same stall → accepted into out0 (no head-of-line blocking).
- Same-cycle drain and refill on out0 with continuous valid/ready → one transfer per cycle and `out0_valid` never drops.
- `flush` pulse with both branches full and `in_valid = 1` → next cycle both valids are 0, no accept occurs, counters unchanged.
- CNT_W=2: push 5 items to out0 → `cnt0` reads 1,2,3,3,3 (saturates, no wrap). `rst` mid-burst → all outputs 0 the next cycle.
